// File: rtl/pc_gen_pkg.sv
// Shared encodings for the next-PC generator: command selectors and control states.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_JAL  = 2'd1,
    SEL_BR   = 2'd2,
    SEL_TRAP = 2'd3
  } next_sel_e;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

endpackage

// File: rtl/pc_gen_unit_if.sv
// Command and fetch handshakes of the next-PC generator; master issues commands and consumes pc.
interface pc_gen_unit_if #(
  parameter int XLEN = 32
);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      next_sel;
  logic            br_taken;
  logic            jalr_en;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] jalr_base;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            pc_ready;
  logic            fault;
  logic [XLEN-1:0] fault_addr;

  modport master (
    output cmd_valid, next_sel, br_taken, jalr_en, imm_j, imm_b, jalr_base, pc_ready,
    input  cmd_ready, pc, pc_valid, fault, fault_addr
  );

  modport slave (
    input  cmd_valid, next_sel, br_taken, jalr_en, imm_j, imm_b, jalr_base, pc_ready,
    output cmd_ready, pc, pc_valid, fault, fault_addr
  );

endinterface

// File: rtl/pc_gen_unit_npc_calc.sv
// Combinational next-PC target mux sharing one XLEN-bit adder across sequential, JAL and branch.
module npc_calc
  import pc_gen_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'('h100),
  parameter int              ILEN_BYTES  = 4
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      next_sel,
  input  logic            br_taken,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] imm_j,
  input  logic [XLEN-1:0] imm_b,
  input  logic [XLEN-1:0] jalr_base,
  output logic [XLEN-1:0] npc
);

  logic [XLEN-1:0] addend;
  logic [XLEN-1:0] sum;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    addend = XLEN'(ILEN_BYTES);
    case (next_sel)
      SEL_JAL: addend = imm_j;
      SEL_BR:  if (br_taken) addend = imm_b;
      default: ;
    endcase
    sum = pc + addend;  // modulo 2^XLEN, carry dropped

    if (jalr_en)                 npc = {jalr_base[XLEN-1:1], 1'b0};
    else if (next_sel == SEL_TRAP) npc = TRAP_VECTOR;
    else                         npc = sum;
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Next-PC generator: holds the fetch PC, buffers one command during fetch stalls, traps misaligned targets.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              ILEN_BYTES   = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input logic          clock,
  input logic          resetn,
  pc_gen_unit_if.slave bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic [XLEN-1:0] npc, load_tgt;
  logic            pc_valid_q, pc_valid_d;
  logic            consumed_q, consumed_d;
  logic            fault_q, fault_d;
  logic            load_en;
  logic            cmd_fire, pc_fire;

  function automatic logic misaligned(input logic [XLEN-1:0] addr);
    return |addr[ALIGN_BITS-1:0];
  endfunction

  npc_calc #(
    .XLEN       (XLEN),
    .TRAP_VECTOR(TRAP_VECTOR),
    .ILEN_BYTES (ILEN_BYTES)
  ) u_npc_calc (
    .pc       (pc_q),
    .next_sel (bus.next_sel),
    .br_taken (bus.br_taken),
    .jalr_en  (bus.jalr_en),
    .imm_j    (bus.imm_j),
    .imm_b    (bus.imm_b),
    .jalr_base(bus.jalr_base),
    .npc      (npc)
  );

  assign bus.cmd_ready  = (state_q == RUN) || (state_q == FAULT);
  assign bus.pc         = pc_q;
  assign bus.pc_valid   = pc_valid_q;
  assign bus.fault      = fault_q;
  assign bus.fault_addr = fault_addr_q;

  assign cmd_fire = bus.cmd_valid & bus.cmd_ready;
  assign pc_fire  = pc_valid_q & bus.pc_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_valid_d   = pc_valid_q;
    consumed_d   = consumed_q | pc_fire;
    pend_d       = pend_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    load_en      = 1'b0;
    load_tgt     = npc;

    unique case (state_q)
      BOOT: begin
        pc_valid_d = 1'b1;
        consumed_d = 1'b0;
        state_d    = RUN;
      end
      RUN: begin
        if (pc_fire) pc_valid_d = 1'b0;
        if (cmd_fire) begin
          if (consumed_q || pc_fire) begin
            load_en = 1'b1;
          end else begin
            pend_d  = npc;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (pc_fire) begin
          load_en  = 1'b1;
          load_tgt = pend_q;
        end
      end
      FAULT: begin
        // Only a plain trap command leaves FAULT; everything else is swallowed.
        if (cmd_fire && !bus.jalr_en && bus.next_sel == SEL_TRAP) begin
          pc_d       = TRAP_VECTOR;
          pc_valid_d = 1'b1;
          consumed_d = 1'b0;
          fault_d    = 1'b0;
          state_d    = RUN;
        end
      end
    endcase

    if (load_en) begin
      if (misaligned(load_tgt)) begin
        fault_d      = 1'b1;
        fault_addr_d = load_tgt;
        pc_valid_d   = 1'b0;
        state_d      = FAULT;
      end else begin
        pc_d       = load_tgt;
        pc_valid_d = 1'b1;
        consumed_d = 1'b0;
        state_d    = RUN;
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      pc_valid_q   <= 1'b0;
      consumed_q   <= 1'b0;
      pend_q       <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      consumed_q   <= consumed_d;
      pend_q       <= pend_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised next-PC generator for the RV32/RV64 fetch stage.
- Holds the architectural PC and presents it to fetch through a valid/ready handshake.
- Accepts next-PC commands (sequential, JAL, conditional branch, trap, JALR) through a second valid/ready handshake.
- Buffers one command while fetch stalls, and detects misaligned targets with a sticky fault state.

Parameters:
- XLEN, 32, PC and operand width in bits.
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset. XLEN-wide.
- TRAP_VECTOR, 32'h0000_0100, target for next_sel=3. XLEN-wide.
- ILEN_BYTES, 4, sequential increment. Power of two.
- ALIGN_BITS, 2, target must have this many LSBs zero. 1 when the compressed extension is enabled.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  next-PC command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- next_sel  in  2  0=PC+ILEN_BYTES, 1=PC+imm_j, 2=branch, 3=TRAP_VECTOR
- br_taken  in  1  branch comparison result, used when next_sel=2
- jalr_en  in  1  overrides next_sel; target={jalr_base[XLEN-1:1],1'b0}
- imm_j  in  XLEN  sign-extended J offset
- imm_b  in  XLEN  sign-extended B offset
- jalr_base  in  XLEN  rs1+imm from the ALU
- pc  out  XLEN  current fetch PC
- pc_valid  out  1  pc not yet consumed by fetch
- pc_ready  in  1  fetch accepts pc when pc_valid&pc_ready
- fault  out  1  misaligned target pending
- fault_addr  out  XLEN  offending target

Behaviour:
- Reset (async assert, sync-released use): state=BOOT, pc=RESET_VECTOR, pc_valid=0, cmd_ready=0, fault=0, fault_addr=0, pending buffer empty.
- BOOT: one cycle. Then pc_valid=1 and cmd_ready=1; go to RUN.
- npc computation (combinational, from pc, not from buffered copies):
  - If jalr_en: target = jalr_base with bit0 cleared.
  - Else next_sel=0: pc+ILEN_BYTES.
  - next_sel=1: pc+imm_j.
  - next_sel=2: br_taken ? pc+imm_b : pc+ILEN_BYTES.
  - next_sel=3: TRAP_VECTOR.
  - All adds are modulo 2^XLEN; carry is discarded and the result is exactly XLEN bits.
- The pending buffer stores the computed npc, not the raw inputs.
- A "consumed" flag is set on pc_valid&pc_ready.
- RUN, command accepted:
  - If the current pc is consumed or pc_ready=1 this cycle: pc<=npc and pc_valid<=1 next cycle. One-cycle latency.
  - Otherwise store npc in the pending buffer, cmd_ready<=0, go to HOLD.
- HOLD:
  - cmd_ready=0 and pc is stable.
  - On pc_valid&pc_ready: pc<=pending, pc_valid=1, buffer cleared, cmd_ready=1, back to RUN.
- A pc that has been consumed with no new command drops pc_valid to 0 until the next command. The same pc is never issued twice.
- Misalignment: a target with any of bits [ALIGN_BITS-1:0] nonzero is not loaded. Instead:
  - fault<=1, fault_addr<=target, pc_valid<=0, state=FAULT.
  - pc keeps its old value.
  - The check applies at load time, including a load from the pending buffer.
- FAULT:
  - cmd_ready=1. Commands other than trap (next_sel=3, jalr_en=0) are accepted and dropped.
  - A trap command sets pc<=TRAP_VECTOR, pc_valid=1, clears fault (fault_addr is kept), and returns to RUN.
- Reset mid-HOLD or mid-FAULT returns to the BOOT state immediately and discards the pending buffer.
- A command arriving in the same cycle as fetch consumption is accepted in RUN with no buffering.
- No combinational path from cmd_valid to pc_valid or pc. Only cmd_ready depends on state alone.

Decomposition:
- Shared package pc_gen_pkg holds:
  - the next_sel encodings (SEL_SEQ, SEL_JAL, SEL_BR, SEL_TRAP);
  - the state encodings (BOOT, RUN, HOLD, FAULT).
- One sub-module, npc_calc: the combinational target mux plus a single XLEN-bit adder. It is reused by the branch predictor later.

Test Plan:
- Reset and boot:
  - Stimulus: resetn low, then high; hold pc_ready=1.
  - Required: pc=0x0 and pc_valid=0 for one cycle, then pc_valid=1; cmd_ready rises with pc_valid.
- Sequential and JAL:
  - Stimulus: sequential command at pc=0x0, then JAL with imm_j=0xFFFFFFF8.
  - Required: pc=0x4, then 0xFFFFFFFC (wraps, no carry).
- Branch:
  - Stimulus: next_sel=2 with br_taken=1, imm_b=0x20 at pc=0x100; then br_taken=0.
  - Required: pc=0x120, then 0x124.
- Stall and buffer:
  - Stimulus: pc_ready=0, issue a sequential command at pc=0x40.
  - Required: cmd_ready=0 next cycle, pc stays 0x40. When pc_ready=1, pc becomes 0x44 one cycle later and cmd_ready=1.
- JALR and misalignment:
  - Stimulus: jalr_base=0x203 → pc=0x202 is still misaligned with ALIGN_BITS=2.
  - Required: fault=1, fault_addr=0x202, pc_valid=0.
  - Then a sequential command is dropped; a trap command gives pc=0x100, fault=0.
- Reset during HOLD:
  - Stimulus: assert resetn while a command is buffered.
  - Required: pc=0x0, buffer empty, and after release the boot sequence repeats.
